// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - radix-2 shift-add multiply sequencer with EXE-stage stall control
module mul_seq_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              op_hi,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              flush,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              ID_EX_Write,
  output logic              EX_MEM_Flush
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam int P_W   = 2 * DATA_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [1:0]        state_q, state_d;
  logic [P_W-1:0]    p_q, p_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              hi_q, hi_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic [DATA_W:0]   upper_sum;
  logic [P_W-1:0]    p_step;
  logic              stall;

  // Upper half never exceeds DATA_W bits before the add, so DATA_W+1 bits hold the carry.
  always_comb begin
    upper_sum = p_q[P_W-1:DATA_W] + (p_q[0] ? {1'b0, a_q} : {(DATA_W+1){1'b0}});
    p_step    = {1'b0, upper_sum, p_q[DATA_W-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    a_d      = a_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_d     = operand_a;
            hi_d    = op_hi;
            p_d     = {{(DATA_W+1){1'b0}}, operand_b};
            cnt_d   = '0;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          p_d   = p_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = ST_DONE;
            result_d = hi_q ? p_step[2*DATA_W-1:DATA_W] : p_step[DATA_W-1:0];
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= ST_IDLE;
      p_q      <= '0;
      a_q      <= '0;
      hi_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Stall is gated by reset so the pipeline sees its released values while held in reset.
  assign stall = arst_n && !flush &&
                 (((state_q == ST_IDLE) && start) || (state_q == ST_BUSY));

  assign busy         = (state_q == ST_BUSY);
  assign result_valid = (state_q == ST_DONE) && !flush;
  assign result       = result_q;

  assign PCWrite      = !stall;
  assign IF_ID_Write  = !stall;
  assign ID_EX_Write  = !stall;
  assign EX_MEM_Flush = stall;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - directed self-checking bench for mul_seq_ctrl
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        start;
  logic        op_hi;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        ID_EX_Write;
  logic        EX_MEM_Flush;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  mul_seq_ctrl #(.DATA_W(32)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .start        (start),
    .op_hi        (op_hi),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .flush        (flush),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .PCWrite      (PCWrite),
    .IF_ID_Write  (IF_ID_Write),
    .ID_EX_Write  (ID_EX_Write),
    .EX_MEM_Flush (EX_MEM_Flush)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at posedge+1 of the start cycle T; returns at the negedge of the DONE cycle.
  task automatic mul_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic hi, input logic [31:0] exp_res, output int done_cyc);
    int lat;
    bit stall_ok;
    bit busy_ok;
    start     = 1'b1;
    operand_a = a;
    operand_b = b;
    op_hi     = hi;
    lat       = -1;
    stall_ok  = 1'b1;
    busy_ok   = 1'b1;
    done_cyc  = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (result_valid) begin
        lat      = i;
        done_cyc = cyc;
        break;
      end
      if (PCWrite || IF_ID_Write || ID_EX_Write || !EX_MEM_Flush) stall_ok = 1'b0;
      if (busy != (i != 0)) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, lat, 33);
    check({tag, "_stall"}, stall_ok, 1);
    check({tag, "_busy"}, busy_ok, 1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_done_pcwrite"}, PCWrite, 1);
    check({tag, "_done_busy"}, busy, 0);
  endtask

  task automatic idle_gap();
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int d1;
    arst_n    = 1'b0;
    start     = 1'b0;
    op_hi     = 1'b0;
    operand_a = '0;
    operand_b = '0;
    flush     = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", result_valid, 0);
    check("rst_result", result, 0);
    check("rst_pcwrite", PCWrite, 1);
    check("rst_ifid", IF_ID_Write, 1);
    check("rst_idex", ID_EX_Write, 1);
    check("rst_exmem", EX_MEM_Flush, 0);

    @(posedge clk); #1;
    arst_n = 1'b1;
    @(posedge clk); #1;

    mul_op("mul7x6", 32'd7, 32'd6, 1'b0, 32'd42, d0);
    idle_gap();
    mul_op("mulhu_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, d0);
    idle_gap();
    mul_op("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, d0);
    idle_gap();

    // Back-to-back: second start lands in the IDLE cycle right after DONE.
    mul_op("b2b_a", 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0001, d0);
    @(posedge clk); #1;
    mul_op("b2b_b", 32'd3, 32'd5, 1'b0, 32'd15, d1);
    check("b2b_gap", d1 - d0, 34);
    @(posedge clk); #1;
    start = 1'b0;
    check("no_third_busy", busy, 0);
    @(negedge clk);
    check("no_third_pcwrite", PCWrite, 1);
    check("no_third_valid", result_valid, 0);
    @(posedge clk); #1;

    // Flush at T+10 of a running multiply.
    start     = 1'b1;
    operand_a = 32'd100;
    operand_b = 32'd200;
    op_hi     = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_pcwrite", PCWrite, 1);
    check("flush_exmem", EX_MEM_Flush, 0);
    check("flush_still_busy", busy, 1);
    check("flush_valid", result_valid, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", busy, 0);
    check("flush_no_valid", result_valid, 0);
    mul_op("after_flush", 32'd9, 32'd11, 1'b0, 32'd99, d0);
    idle_gap();

    // Asynchronous reset mid-cycle at T+5, start held high across release.
    start     = 1'b1;
    operand_a = 32'h0000_1234;
    operand_b = 32'h0000_0010;
    op_hi     = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", result_valid, 0);
    check("arst_result", result, 0);
    check("arst_pcwrite", PCWrite, 1);
    check("arst_exmem", EX_MEM_Flush, 0);
    @(posedge clk); #1;
    arst_n = 1'b1;
    mul_op("after_rst", 32'h0000_1234, 32'h0000_0010, 1'b0, 32'h0001_2340, d0);
    idle_gap();

    mul_op("zero_x_dead", 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, d0);
    idle_gap();
    mul_op("dead_x_one", 32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 32'hDEAD_BEEF, d0);
    idle_gap();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
